program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writes a program into the FRANK6000 CPU instruction memory, then starts and monitors execution.
- Accepts a byte stream with a valid/ready handshake: one length byte, then big-endian 16-bit instruction words.
- Drives the CPU memory-write port (instruction, address, write-enable).
- Resets the CPU, asserts the run signal, waits for the CPU loop flag, then captures the working register as the result.

Parameters:
- addr_width, 8, width of the instruction address and word counter. Legal range is 1..8.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  begins a load; sampled only in IDLE.
- i_byte  input  8  incoming stream byte.
- i_byte_valid  input  1  i_byte is valid this cycle.
- o_byte_ready  output  1  loader accepts i_byte this cycle. A transfer occurs when valid and ready are both high.
- i_loopf  input  1  CPU loop/halt flag.
- i_WREG  input  8  CPU working register.
- o_instr  output  16  instruction word to the CPU memory.
- o_instr_addr  output  addr_width  write address to the CPU memory.
- o_we  output  1  CPU instruction-memory write enable.
- o_cpu_rst  output  1  one-cycle reset pulse to the CPU.
- o_ON  output  1  CPU run enable.
- o_result  output  8  WREG captured at halt.
- o_done  output  1  one-cycle pulse when o_result updates.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset:
  - State goes to IDLE.
  - o_byte_ready, o_we, o_cpu_rst, o_ON, o_done, o_busy are 0.
  - o_instr, o_instr_addr, o_result, and the word counters are 0.
  - Reset mid-load or mid-run aborts immediately. o_ON drops on the cycle after reset is sampled. CPU memory contents are left as written.
- States: IDLE, LEN, HI, LO, WRITE, CPURST, RUN.
- IDLE
  - i_start=1 → LEN.
  - Bytes are not accepted (o_byte_ready=0).
- LEN
  - o_byte_ready=1.
  - On transfer: N = i_byte[addr_width-1:0], where N=0 means 2^addr_width words. Clear the address counter → HI.
- HI
  - o_byte_ready=1.
  - On transfer: latch the high byte → LO.
- LO
  - o_byte_ready=1.
  - On transfer: latch the low byte → WRITE.
- WRITE (exactly one cycle)
  - o_byte_ready=0, o_we=1.
  - o_instr = {hi, lo}; o_instr_addr = current address counter.
  - Then increment the counter modulo 2^addr_width.
  - If this was word N → CPURST; else → HI.
- CPURST (one cycle)
  - o_cpu_rst=1, o_ON=0 → RUN.
  - Purpose: clears CPU PC/WREG/STATUS/stack so execution starts at address 0.
- RUN
  - o_ON=1.
  - When i_loopf=1: o_result ← i_WREG, o_done=1 for one cycle, o_ON=0 → IDLE.
  - i_loopf is ignored in all other states.
- Latency:
  - Final LO byte transfer → o_we high next cycle.
  - o_cpu_rst follows in the cycle after WRITE; o_ON goes high the cycle after o_cpu_rst.
  - i_loopf sampled high → o_done/o_result valid and o_ON low on the next cycle.
- Handshake:
  - i_byte_valid with o_byte_ready=0 is not consumed; the sender must hold the byte.
  - A stalled stream (valid=0) holds state indefinitely; there is no timeout.
- i_start is ignored outside IDLE. i_start asserted in the same cycle IDLE is re-entered is ignored; it is honoured from the next cycle.
- o_we is never asserted while o_ON=1. o_instr_addr holds its last value when o_we=0.
- Simultaneous i_rst and any other event: reset wins.

Test Plan:
- Basic load/run:
  - Stimulus: i_start; bytes 0x02, 0xA1, 0x05, 0x00, 0x00.
  - Required: o_we pulses with (addr 0, 0xA105) then (addr 1, 0x0000); o_cpu_rst pulse; o_ON=1.
  - Then drive i_loopf=1 with i_WREG=0x2A → o_result=0x2A, o_done pulses once, o_ON=0, o_busy=0.
- Back-pressure:
  - Stimulus: valid toggled with random gaps; byte held during WRITE.
  - Required: identical writes to the basic case; no byte lost or duplicated; o_byte_ready=0 during WRITE, CPURST, RUN, IDLE.
- Full depth:
  - Stimulus: length byte 0x00 with addr_width=8.
  - Required: 256 writes at addresses 0..255 with data = address replicated ({a, a}); transition to CPURST after address 255; counter wraps to 0.
- Reset mid-load:
  - Stimulus: i_rst after 3 of 5 words.
  - Required: next cycle state IDLE, all outputs 0. A new i_start with length 0x01, word 0x1234 writes addr 0 = 0x1234.
- Stray inputs:
  - Stimulus: i_loopf=1 in IDLE/LEN; i_start pulsed during HI.
  - Required: no o_done, no state change, load continues normally.
- End-to-end with CPU:
  - Stimulus: load a program ending in an all-zero instruction.
  - Required: o_result equals the expected WREG, and CPU PC starts at 0 after o_cpu_rst.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream, CPU memory-write and run/monitor signals between a program source and the loader.
// The loader takes the slave side; the stream source / CPU side takes the master side.
interface program_loader_if #(
   parameter int addr_width = 8
);
   logic                  i_start;
   logic [7:0]            i_byte;
   logic                  i_byte_valid;
   logic                  o_byte_ready;
   logic                  i_loopf;
   logic [7:0]            i_WREG;
   logic [15:0]           o_instr;
   logic [addr_width-1:0] o_instr_addr;
   logic                  o_we;
   logic                  o_cpu_rst;
   logic                  o_ON;
   logic [7:0]            o_result;
   logic                  o_done;
   logic                  o_busy;

   modport slave (
      input  i_start, i_byte, i_byte_valid, i_loopf, i_WREG,
      output o_byte_ready, o_instr, o_instr_addr, o_we, o_cpu_rst, o_ON,
             o_result, o_done, o_busy
   );

   modport master (
      output i_start, i_byte, i_byte_valid, i_loopf, i_WREG,
      input  o_byte_ready, o_instr, o_instr_addr, o_we, o_cpu_rst, o_ON,
             o_result, o_done, o_busy
   );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, big-endian word stream into the FRANK6000 instruction memory,
// then resets and runs the CPU until its loop flag, capturing WREG as the result.
module program_loader #(
   parameter int addr_width = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   program_loader_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, CPURST, RUN} state_t;

   state_t                state_q, state_d;
   logic [addr_width-1:0] len_q, len_d;
   logic [addr_width-1:0] addr_q, addr_d;
   logic [addr_width-1:0] instr_addr_q, instr_addr_d;
   logic [addr_width-1:0] last_addr;
   logic [7:0]            hi_q, hi_d;
   logic [7:0]            result_q, result_d;
   logic [15:0]           instr_q, instr_d;
   logic                  ready_q, ready_d;
   logic                  we_q, we_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  on_q, on_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  xfer;

   // ready_q is high exactly in LEN/HI/LO, so it doubles as the accept qualifier
   assign xfer      = bus.i_byte_valid && ready_q;
   // a length of 0 wraps to all-ones here, which selects 2^addr_width words
   assign last_addr = len_q - 1'b1;

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      addr_d       = addr_q;
      instr_addr_d = instr_addr_q;
      hi_d         = hi_q;
      instr_d      = instr_q;
      result_d     = result_q;
      done_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.i_start) state_d = LEN;
         end
         LEN: begin
            if (xfer) begin
               len_d   = bus.i_byte[addr_width-1:0];
               addr_d  = '0;
               state_d = HI;
            end
         end
         HI: begin
            if (xfer) begin
               hi_d    = bus.i_byte;
               state_d = LO;
            end
         end
         LO: begin
            if (xfer) begin
               instr_d      = {hi_q, bus.i_byte};
               instr_addr_d = addr_q;
               state_d      = WRITE;
            end
         end
         WRITE: begin
            addr_d  = addr_q + 1'b1;
            state_d = (addr_q == last_addr) ? CPURST : HI;
         end
         CPURST: begin
            state_d = RUN;
         end
         RUN: begin
            if (bus.i_loopf) begin
               result_d = bus.i_WREG;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // strobes are decoded from the next state so every output comes straight from a flop
      ready_d   = (state_d == LEN) || (state_d == HI) || (state_d == LO);
      we_d      = (state_d == WRITE);
      cpu_rst_d = (state_d == CPURST);
      on_d      = (state_d == RUN);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         len_q        <= '0;
         addr_q       <= '0;
         instr_addr_q <= '0;
         hi_q         <= '0;
         instr_q      <= '0;
         result_q     <= '0;
         ready_q      <= 1'b0;
         we_q         <= 1'b0;
         cpu_rst_q    <= 1'b0;
         on_q         <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         addr_q       <= addr_d;
         instr_addr_q <= instr_addr_d;
         hi_q         <= hi_d;
         instr_q      <= instr_d;
         result_q     <= result_d;
         ready_q      <= ready_d;
         we_q         <= we_d;
         cpu_rst_q    <= cpu_rst_d;
         on_q         <= on_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.o_byte_ready = ready_q;
   assign bus.o_instr      = instr_q;
   assign bus.o_instr_addr = instr_addr_q;
   assign bus.o_we         = we_q;
   assign bus.o_cpu_rst    = cpu_rst_q;
   assign bus.o_ON         = on_q;
   assign bus.o_result     = result_q;
   assign bus.o_done       = done_q;
   assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes/results are queued by the stimulus
// and popped by a negedge monitor; a toy CPU model closes the loop for end-to-end runs.
module tb_program_loader;

   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   program_loader_if #(.addr_width(AW)) bus ();

   program_loader #(.addr_width(AW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   wr_t         exp_wr_q[$];
   int          exp_res_q[$];
   logic [15:0] prog[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // loop flag / WREG come either from the bench directly or from the toy CPU
   logic       cpu_auto  = 1'b0;
   logic       man_loopf = 1'b0;
   logic [7:0] man_wreg  = 8'h00;
   logic       cpu_loopf = 1'b0;
   logic [7:0] cpu_wreg  = 8'h00;
   assign bus.i_loopf = cpu_auto ? cpu_loopf : man_loopf;
   assign bus.i_WREG  = cpu_auto ? cpu_wreg  : man_wreg;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Toy CPU: adds low bytes of nonzero instructions into WREG, halts on an all-zero word.
   logic [15:0]   cmem [DEPTH];
   logic [AW-1:0] pc     = '0;
   logic          halted = 1'b1;
   always @(negedge clk) begin
      if (bus.o_we) cmem[bus.o_instr_addr] <= bus.o_instr;
      if (bus.o_cpu_rst) begin
         pc        <= '0;
         cpu_wreg  <= 8'h00;
         cpu_loopf <= 1'b0;
         halted    <= 1'b0;
      end else if (!bus.o_ON) begin
         cpu_loopf <= 1'b0;
      end else if (!halted) begin
         if (cmem[pc] == 16'h0000) begin
            cpu_loopf <= 1'b1;
            halted    <= 1'b1;
         end else begin
            cpu_wreg <= cpu_wreg + cmem[pc][7:0];
            pc       <= pc + 1'b1;
         end
      end
   end

   // Monitor
   logic prev_we = 1'b0, prev_cpu_rst = 1'b0, prev_on = 1'b0;
   always @(negedge clk) begin
      wr_t e;
      int  r;
      if (!rst) begin
         if (bus.o_we) begin
            chk("write_expected", exp_wr_q.size() > 0, 1);
            if (exp_wr_q.size() > 0) begin
               e = exp_wr_q.pop_front();
               chk("wr_addr", bus.o_instr_addr, e.addr);
               chk("wr_data", bus.o_instr, e.data);
            end
            chk("we_while_on", bus.o_ON, 0);
         end
         if (bus.o_cpu_rst) begin
            chk("cpurst_after_write", prev_we, 1);
            chk("writes_left_at_cpurst", exp_wr_q.size(), 0);
            chk("on_during_cpurst", bus.o_ON, 0);
         end
         if (bus.o_ON && !prev_on) chk("on_after_cpurst", prev_cpu_rst, 1);
         if (bus.o_done) begin
            chk("done_expected", exp_res_q.size() > 0, 1);
            if (exp_res_q.size() > 0) begin
               r = exp_res_q.pop_front();
               chk("result", bus.o_result, r);
            end
            chk("on_at_done", bus.o_ON, 0);
            chk("busy_at_done", bus.o_busy, 0);
         end
         if (bus.o_we || bus.o_cpu_rst || bus.o_ON || !bus.o_busy)
            chk("ready_low", bus.o_byte_ready, 0);
      end
      prev_we      <= bus.o_we;
      prev_cpu_rst <= bus.o_cpu_rst;
      prev_on      <= bus.o_ON;
   end

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int g;
      int t;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      bus.i_byte_valid = 1'b0;
      repeat (g) begin
         bus.i_byte = 8'($urandom);
         @(negedge clk);
      end
      bus.i_byte       = b;
      bus.i_byte_valid = 1'b1;
      t = 0;
      while (!bus.o_byte_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!bus.o_byte_ready) begin
         chk("byte_accept_timeout", t, 0);
         bus.i_byte_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.i_byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   task automatic send_word(input int idx, input int maxgap);
      exp_wr_q.push_back('{addr: idx % DEPTH, data: int'(prog[idx])});
      send_byte(prog[idx][15:8], maxgap);
      send_byte(prog[idx][7:0], maxgap);
   endtask

   task automatic load(input logic [7:0] lenb, input int maxgap);
      pulse_start();
      send_byte(lenb, maxgap);
      for (int i = 0; i < prog.size(); i++) send_word(i, maxgap);
   endtask

   task automatic wait_on_high();
      int t = 0;
      while (!bus.o_ON && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("on_reached", bus.o_ON, 1);
   endtask

   task automatic wait_results_drained();
      int t = 0;
      while (exp_res_q.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("result_seen", exp_res_q.size(), 0);
   endtask

   task automatic run_manual(input logic [7:0] w);
      wait_on_high();
      repeat ($urandom_range(0, 4)) @(negedge clk);
      man_wreg  = w;
      man_loopf = 1'b1;
      exp_res_q.push_back(int'(w));
      @(negedge clk);
      man_loopf = 1'b0;
      man_wreg  = 8'($urandom);
      wait_results_drained();
      @(negedge clk);
      chk("result_hold", bus.o_result, w);
      chk("idle_not_busy", bus.o_busy, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},   bus.o_byte_ready, 0);
      chk({tag, "_we"},      bus.o_we, 0);
      chk({tag, "_cpu_rst"}, bus.o_cpu_rst, 0);
      chk({tag, "_on"},      bus.o_ON, 0);
      chk({tag, "_done"},    bus.o_done, 0);
      chk({tag, "_busy"},    bus.o_busy, 0);
      chk({tag, "_instr"},   bus.o_instr, 0);
      chk({tag, "_addr"},    bus.o_instr_addr, 0);
      chk({tag, "_result"},  bus.o_result, 0);
   endtask

   initial begin
      int n;
      int sum;
      int mism;
      logic [15:0] w;

      bus.i_start      = 1'b0;
      bus.i_byte       = 8'h00;
      bus.i_byte_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Basic load and run
      prog = '{16'hA105, 16'h0000};
      load(8'h02, 0);
      run_manual(8'h2A);

      // Back-pressure with random gaps
      repeat (3) begin
         load(8'h02, 4);
         run_manual(8'($urandom));
      end

      // Stray loop flag in IDLE/LEN and stray start during HI
      man_loopf = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_loopf_busy", bus.o_busy, 0);
      pulse_start();
      repeat (2) @(negedge clk);
      chk("len_loopf_busy", bus.o_busy, 1);
      man_loopf = 1'b0;
      prog = '{16'h0BEE, 16'hC0DE, 16'h0000};
      send_byte(8'h03, 2);
      pulse_start();
      chk("hi_start_busy", bus.o_busy, 1);
      chk("hi_start_ready", bus.o_byte_ready, 1);
      for (int i = 0; i < prog.size(); i++) send_word(i, 2);
      run_manual(8'hC3);

      // Full depth: length 0 selects every address
      prog.delete();
      for (int a = 0; a < DEPTH; a++) prog.push_back({8'(a), 8'(a)});
      load(8'h00, 0);
      run_manual(8'h5A);
      chk("addr_hold_full", bus.o_instr_addr, DEPTH - 1);

      // Reset after 3 of 5 words
      prog = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
      pulse_start();
      send_byte(8'h05, 1);
      for (int i = 0; i < 3; i++) send_word(i, 1);
      @(negedge clk);
      chk("writes_before_reset", exp_wr_q.size(), 0);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midload_rst");
      rst = 1'b0;
      exp_wr_q.delete();
      @(negedge clk);
      prog = '{16'h1234};
      load(8'h01, 0);
      run_manual(8'h77);

      // Reset while running drops the run enable
      prog = '{16'h0001, 16'h0002};
      load(8'h02, 1);
      wait_on_high();
      rst = 1'b1;
      @(negedge clk);
      chk("on_drop_on_reset", bus.o_ON, 0);
      chk("busy_drop_on_reset", bus.o_busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // End-to-end with the toy CPU, random programs ending in an all-zero word
      cpu_auto = 1'b1;
      repeat (5) begin
         prog.delete();
         n   = int'($urandom_range(2, 12));
         sum = 0;
         for (int i = 0; i < n - 1; i++) begin
            w = 16'($urandom_range(1, 65535));
            prog.push_back(w);
            sum += int'(w[7:0]);
         end
         prog.push_back(16'h0000);
         load(8'(n), 3);
         exp_res_q.push_back(sum % 256);
         wait_results_drained();
         mism = 0;
         for (int i = 0; i < n; i++) if (cmem[i] !== prog[i]) mism++;
         chk("cpu_mem_contents", mism, 0);
         @(negedge clk);
      end
      cpu_auto = 1'b0;

      repeat (3) @(negedge clk);
      chk("no_pending_writes", exp_wr_q.size(), 0);
      chk("no_pending_results", exp_res_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, checks so far %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
